multi_switch_debouncer: RTL and testbench

Parametrised, multi-channel successor to the single-button debouncer. Each of NUM_CH raw switch/button inputs passes through a 2-FF synchroniser, optional polarity inversion and a counter-based stability filter. The block produces a debounced level, one-cycle press/release pulses and an optional long-press pulse per channel. It sits between board pins and control logic such as NCO and LED controllers, in the clk_main domain.

---
 rtl/switch_debouncer_pkg.sv | 19 +
 rtl/switch_debounce_ch.sv | 107 ++++++++++
 rtl/multi_switch_debouncer.sv | 42 ++++
 tb/tb_multi_switch_debouncer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
package switch_debouncer_pkg;

    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic longp;
    } ch_status_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One debounce channel: synchroniser, polarity, stability filter, edge pulses and hold counter.
// Hold counter and longPress logic exist only when SWITCH_DEBOUNCER_LONG_PRESS_EN is defined.
module switch_debounce_ch
    import switch_debouncer_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES   = 1000000,
    parameter int   LONG_PRESS_CYCLES = 100000000,
    parameter logic INVERT            = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic       i_tick,
    input  logic       i_raw,
    output ch_status_t o_status
);

    localparam int             DW      = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_params
        $error("switch_debounce_ch: cycle thresholds must be >= 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_s;
    logic                   w_differ;
    logic                   w_accept;
    logic                   w_longp;

    assign w_s      = r_sync[SYNC_STAGES-1] ^ INVERT;
    assign w_differ = (w_s != r_level);
    assign w_accept = w_differ && i_tick && (r_cnt == DB_LAST);

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Counter only runs while the synchronised input disagrees with the accepted level.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_accept && w_s;
            r_release <= w_accept && !w_s;
            if (!w_differ || w_accept) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_level <= w_s;
            end
        end
    end

`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
    localparam int            HW        = clog2_min1(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] r_hold;
    logic          r_hold_done;
    logic          r_longp;

    // r_hold_done keeps the counter saturated so a press yields a single pulse.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_hold      <= '0;
            r_hold_done <= 1'b0;
            r_longp     <= 1'b0;
        end else begin
            r_longp <= 1'b0;
            if (!r_level) begin
                r_hold      <= '0;
                r_hold_done <= 1'b0;
            end else if (i_tick && !r_hold_done) begin
                if (r_hold == HOLD_LAST) begin
                    r_longp     <= 1'b1;
                    r_hold_done <= 1'b1;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end
        end
    end

    assign w_longp = r_longp;
`else
    assign w_longp = 1'b0;
`endif

    assign o_status.level = r_level;
    assign o_status.press = r_press;
    assign o_status.rel   = r_release;
    assign o_status.longp = w_longp;

endmodule

// File: rtl/multi_switch_debouncer.sv
// NUM_CH independent debounce channels packed onto per-function output vectors.
// Optional long-press detection: define SWITCH_DEBOUNCER_LONG_PRESS_EN.
module multi_switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int                NUM_CH            = 4,
    parameter int                DEBOUNCE_CYCLES   = 1000000,
    parameter int                LONG_PRESS_CYCLES = 100000000,
    parameter logic [NUM_CH-1:0] INVERT_MASK       = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              tick,
    input  logic [NUM_CH-1:0] buttonIn,
    output logic [NUM_CH-1:0] buttonOut,
    output logic [NUM_CH-1:0] pressPulse,
    output logic [NUM_CH-1:0] releasePulse,
    output logic [NUM_CH-1:0] longPress
);

    ch_status_t w_status [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        switch_debounce_ch #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
            .INVERT            (INVERT_MASK[gi])
        ) u_ch (
            .i_clk    (clk),
            .i_srst   (srst),
            .i_tick   (tick),
            .i_raw    (buttonIn[gi]),
            .o_status (w_status[gi])
        );

        assign buttonOut[gi]    = w_status[gi].level;
        assign pressPulse[gi]   = w_status[gi].press;
        assign releasePulse[gi] = w_status[gi].rel;
        assign longPress[gi]    = w_status[gi].longp;
    end

endmodule

// File: tb/tb_multi_switch_debouncer.sv
// Directed bench for multi_switch_debouncer with a cycle-level reference model.
// Long-press expectations follow SWITCH_DEBOUNCER_LONG_PRESS_EN.
module tb_multi_switch_debouncer;

    localparam int         NUM_CH = 4;
    localparam int         DB     = 8;
    localparam int         LP     = 32;
    localparam logic [3:0] INV    = 4'b0100;
`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       tick = 1'b1;
    logic [3:0] buttonIn = 4'b0100;
    logic [3:0] buttonOut, pressPulse, releasePulse, longPress;

    int checks = 0;
    int passed = 0;
    bit cmp_en = 1'b0;
    bit ps_mode = 1'b0;
    int ps_cnt = 0;

    // Model state: the sampled raw history, accepted level and tick counts.
    logic [3:0] inv_mask = INV;
    bit   m_pipe0 [NUM_CH];
    bit   m_pipe1 [NUM_CH];
    bit   m_level [NUM_CH];
    bit   m_press [NUM_CH];
    bit   m_rel   [NUM_CH];
    bit   m_long  [NUM_CH];
    int   m_dis   [NUM_CH];
    int   m_held  [NUM_CH];
    bit   m_s, m_old;

    multi_switch_debouncer #(
        .NUM_CH            (NUM_CH),
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP),
        .INVERT_MASK       (INV)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .tick         (tick),
        .buttonIn     (buttonIn),
        .buttonOut    (buttonOut),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .longPress    (longPress)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Accept a new value once it has disagreed with the level for DB consecutive ticks;
    // long press fires on the LP-th tick counted after the level went high.
    always @(posedge clk) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (srst) begin
                m_pipe0[ch] = 1'b0;
                m_pipe1[ch] = 1'b0;
                m_level[ch] = 1'b0;
                m_press[ch] = 1'b0;
                m_rel[ch]   = 1'b0;
                m_long[ch]  = 1'b0;
                m_dis[ch]   = 0;
                m_held[ch]  = 0;
            end else begin
                m_s   = m_pipe1[ch] ^ inv_mask[ch];
                m_old = m_level[ch];
                m_press[ch] = 1'b0;
                m_rel[ch]   = 1'b0;
                m_long[ch]  = 1'b0;
                if (!m_old) begin
                    m_held[ch] = 0;
                end else if (tick && m_held[ch] < LP) begin
                    m_held[ch]++;
                    m_long[ch] = LP_EN && (m_held[ch] == LP);
                end
                if (m_s == m_old) begin
                    m_dis[ch] = 0;
                end else if (tick) begin
                    m_dis[ch]++;
                    if (m_dis[ch] == DB) begin
                        m_level[ch] = m_s;
                        m_press[ch] = m_s;
                        m_rel[ch]   = !m_s;
                        m_dis[ch]   = 0;
                    end
                end
                m_pipe1[ch] = m_pipe0[ch];
                m_pipe0[ch] = buttonIn[ch];
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] e_lvl, e_prs, e_rel, e_lng;
        if (cmp_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                e_lvl[ch] = m_level[ch];
                e_prs[ch] = m_press[ch];
                e_rel[ch] = m_rel[ch];
                e_lng[ch] = m_long[ch];
            end
            check("model_buttonOut", buttonOut, e_lvl);
            check("model_pressPulse", pressPulse, e_prs);
            check("model_releasePulse", releasePulse, e_rel);
            check("model_longPress", longPress, e_lng);
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (ps_mode) begin
                ps_cnt++;
                tick = (ps_cnt % 4 == 0);
            end
        end
    endtask

    initial begin
        adv(1);
        cmp_en = 1'b1;
        adv(2);
        check("reset_buttonOut", buttonOut, 4'b0000);
        check("reset_pressPulse", pressPulse, 4'b0000);
        check("reset_releasePulse", releasePulse, 4'b0000);
        check("reset_longPress", longPress, 4'b0000);
        srst = 1'b0;
        $display("txn reset: outputs cleared");

        adv(15);
        check("invert_idle", buttonOut | pressPulse, 4'b0000);
        $display("txn invert idle: ch2 raw high reads as released");

        buttonIn[0] = 1'b1;
        adv(9);
        check("press_edge9", buttonOut, 4'b0000);
        adv(1);
        check("press_edge10_level", buttonOut, 4'b0001);
        check("press_edge10_pulse", pressPulse, 4'b0001);
        adv(1);
        check("press_pulse_one_cycle", pressPulse, 4'b0000);
        adv(30);
        check("long_before", longPress, 4'b0000);
        adv(1);
        check("long_fire", longPress, LP_EN ? 4'b0001 : 4'b0000);
        adv(1);
        check("long_after", longPress, 4'b0000);
        adv(18);
        buttonIn[0] = 1'b0;
        adv(10);
        check("release_pulse", releasePulse, 4'b0001);
        check("release_level", buttonOut, 4'b0000);
        $display("txn clean press/long hold/release on ch0");

        buttonIn[0] = 1'b1;
        adv(10);
        check("short_press", pressPulse, 4'b0001);
        adv(10);
        buttonIn[0] = 1'b0;
        adv(10);
        check("short_release", releasePulse, 4'b0001);
        adv(20);
        $display("txn short hold on ch0: no long press");

        buttonIn[2] = 1'b0;
        adv(9);
        check("invert_edge9", buttonOut, 4'b0000);
        adv(1);
        check("invert_level", buttonOut, 4'b0100);
        check("invert_pulse", pressPulse, 4'b0100);
        buttonIn[2] = 1'b1;
        adv(12);
        $display("txn inverted press on ch2");

        for (int i = 0; i < 12; i++) begin
            buttonIn[1] = ~buttonIn[1];
            adv(3);
        end
        buttonIn[1] = 1'b1;
        adv(9);
        check("bounce_edge9", buttonOut, 4'b0000);
        adv(1);
        check("bounce_level", buttonOut, 4'b0010);
        check("bounce_pulse", pressPulse, 4'b0010);
        buttonIn[1] = 1'b0;
        adv(12);
        $display("txn bounce on ch1 then settle");

        buttonIn = buttonIn | 4'b1001;
        adv(10);
        check("simul_press", pressPulse, 4'b1001);
        buttonIn = buttonIn & 4'b0110;
        adv(10);
        check("simul_release", releasePulse, 4'b1001);
        adv(4);
        $display("txn simultaneous ch0+ch3");

        ps_mode = 1'b1;
        ps_cnt = 0;
        tick = 1'b1;
        buttonIn[3] = 1'b1;
        adv(32);
        check("prescale_edge32", buttonOut, 4'b0000);
        adv(1);
        check("prescale_level", buttonOut, 4'b1000);
        check("prescale_pulse", pressPulse, 4'b1000);
        buttonIn[3] = 1'b0;
        adv(44);
        ps_cnt = 0;
        tick = 1'b1;
        buttonIn[3] = 1'b1;
        adv(28);
        buttonIn[3] = 1'b0;
        adv(44);
        check("prescale_glitch_rejected", buttonOut, 4'b0000);
        ps_mode = 1'b0;
        tick = 1'b1;
        $display("txn prescaled press and 7-tick glitch on ch3");

        buttonIn[1] = 1'b1;
        adv(12);
        check("pre_reset_level", buttonOut, 4'b0010);
        buttonIn[0] = 1'b1;
        adv(7);
        srst = 1'b1;
        adv(2);
        check("midreset_level", buttonOut, 4'b0000);
        check("midreset_pulses", pressPulse | releasePulse | longPress, 4'b0000);
        srst = 1'b0;
        adv(9);
        check("requal_edge9", buttonOut, 4'b0000);
        adv(1);
        check("requal_level", buttonOut, 4'b0011);
        check("requal_pulse", pressPulse, 4'b0011);
        buttonIn = 4'b0100;
        adv(14);
        check("final_idle", buttonOut, 4'b0000);
        $display("txn reset mid-debounce and requalification");

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
